alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, purely combinational ALU.
// A requester is granted in IDLE. Its operation is held in local registers
// for one EXEC cycle. The ALU outputs are then captured and presented as a
// response until the consumer accepts it.

package alu_arbiter_pkg;

   // Operation codes understood by the shared ALU.
   // ALU_SLL must stay at zero because it is the reset value of alu_op.
   typedef enum logic [2:0] {
      ALU_SLL = 3'd0,
      ALU_SRL = 3'd1,
      ALU_SRA = 3'd2,
      ALU_ADD = 3'd3,
      ALU_SUB = 3'd4,
      ALU_AND = 3'd5,
      ALU_OR  = 3'd6,
      ALU_XOR = 3'd7
   } aluop_t;

endpackage

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST,

   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  aluop_t        req_op0,
   input  aluop_t        req_op1,
   input  logic [DW-1:0] req_a0,
   input  logic [DW-1:0] req_a1,
   input  logic [DW-1:0] req_b0,
   input  logic [DW-1:0] req_b1,

   output logic          resp_valid,
   input  logic          resp_ready,
   output logic          resp_id,
   output logic [DW-1:0] resp_result,
   output logic          resp_neg,
   output logic          resp_ovf,
   output logic          resp_zero,

   output aluop_t        alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_neg,
   input  logic          alu_ovf,
   input  logic          alu_zero,

   output logic          busy,
   output logic [CW-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;

   // Index of the requester served most recently.
   // It resets to 1 so that requester 0 wins the first tie.
   logic          rr_last;

   logic          grant_idx;
   logic [1:0]    req_ready_c;
   logic          accept;
   logic          resp_fire;

   aluop_t        hold_op;
   logic [DW-1:0] hold_a;
   logic [DW-1:0] hold_b;
   logic          hold_id;

   logic          resp_id_q;
   logic [DW-1:0] resp_result_q;
   logic          resp_neg_q;
   logic          resp_ovf_q;
   logic          resp_zero_q;
   logic [CW-1:0] op_count_q;

   // Pick the requester to grant.
   // A lone requester always wins. On a tie, the one not served last wins.
   always_comb begin
      grant_idx = 1'b0;
      case (req_valid)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~rr_last;
         default: grant_idx = 1'b0;
      endcase
   end

   // Next-state logic plus the handshake strobes derived from the current state.
   always_comb begin
      state_next  = state;
      req_ready_c = 2'b00;
      accept      = 1'b0;
      resp_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready_c = grant_idx ? 2'b10 : 2'b01;
               accept      = 1'b1;
               state_next  = EXEC;
            end
         end
         EXEC: begin
            state_next = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_fire  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   // Reset drops any operation in flight without producing a response.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Latch the granted requester's operation.
   // After this point, changes on the request inputs cannot disturb the ALU.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_op <= ALU_SLL;
         hold_a  <= '0;
         hold_b  <= '0;
         hold_id <= 1'b0;
      end else if (accept) begin
         hold_op <= grant_idx ? req_op1 : req_op0;
         hold_a  <= grant_idx ? req_a1  : req_a0;
         hold_b  <= grant_idx ? req_b1  : req_b0;
         hold_id <= grant_idx;
      end
   end

   // Capture the ALU outputs at the end of the execute cycle.
   // The response then stays frozen while the consumer stalls.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
         resp_neg_q    <= 1'b0;
         resp_ovf_q    <= 1'b0;
         resp_zero_q   <= 1'b0;
      end else if (state == EXEC) begin
         resp_id_q     <= hold_id;
         resp_result_q <= alu_result;
         resp_neg_q    <= alu_neg;
         resp_ovf_q    <= alu_ovf;
         resp_zero_q   <= alu_zero;
      end
   end

   // On each completed response handshake, remember who was served
   // and bump the completed-operation counter (it wraps naturally).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_last    <= 1'b1;
         op_count_q <= '0;
      end else if (resp_fire) begin
         rr_last    <= resp_id_q;
         op_count_q <= op_count_q + CW'(1);
      end
   end

   // req_ready is combinational from req_valid, so it is forced low
   // explicitly while reset is held.
   assign req_ready   = RST ? 2'b00 : req_ready_c;

   assign resp_valid  = (state == RESP);
   assign busy        = (state != IDLE);

   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_neg    = resp_neg_q;
   assign resp_ovf    = resp_ovf_q;
   assign resp_zero   = resp_zero_q;
   assign op_count    = op_count_q;

   assign alu_op      = hold_op;
   assign alu_a       = hold_a;
   assign alu_b       = hold_b;

endmodule
